// File: rtl/synd_cal_ctrl_seq_pkg.sv
// Shared definitions for the syndrome sequencer: field width, the reduction constant
// of x^10+x^3+1, and the controller state encoding.
package synd_cal_ctrl_seq_pkg;

    localparam int GF_LEN = 10;

    // Low bits of the primitive polynomial, XORed in when alpha stepping carries out of the MSB
    localparam logic [GF_LEN-1:0] PRIM_POLY_LOW = 10'h009;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef logic [GF_LEN-1:0] gf_elem_t;

    typedef struct packed {
        gf_elem_t s1;
        gf_elem_t s3;
        gf_elem_t s5;
    } synd_set_t;

endpackage

// File: rtl/synd_cal_ctrl_seq_if.sv
// Syndrome hand-off bus towards the key-equation stage (valid/ready).
// SYND_CTRL_ZERO_FLAG_EN adds the all-zero-syndrome flag.
interface synd_cal_ctrl_seq_if;
    import synd_cal_ctrl_seq_pkg::*;

    gf_elem_t out_synd1;
    gf_elem_t out_synd3;
    gf_elem_t out_synd5;
    logic     out_synd_valid;
    logic     in_synd_ready;
`ifdef SYND_CTRL_ZERO_FLAG_EN
    logic     out_synd_zero;
`endif

    modport master (
        output out_synd1,
        output out_synd3,
        output out_synd5,
        output out_synd_valid,
`ifdef SYND_CTRL_ZERO_FLAG_EN
        output out_synd_zero,
`endif
        input  in_synd_ready
    );

    modport slave (
        input  out_synd1,
        input  out_synd3,
        input  out_synd5,
        input  out_synd_valid,
`ifdef SYND_CTRL_ZERO_FLAG_EN
        input  out_synd_zero,
`endif
        output in_synd_ready
    );

endinterface

// File: rtl/synd_cal_ctrl_seq_gf10_alpha_step.sv
// Combinational multiply-by-alpha in GF(2^10); shared with the Chien search stage.
module gf10_alpha_step
    import synd_cal_ctrl_seq_pkg::*;
(
    input  gf_elem_t i_a,
    output gf_elem_t o_a_x
);

    assign o_a_x = {i_a[GF_LEN-2:0], 1'b0} ^ (i_a[GF_LEN-1] ? PRIM_POLY_LOW : '0);

endmodule

// File: rtl/synd_cal_ctrl_seq.sv
// Syndrome sequencer: walks alpha^i over a serial codeword, fires the external S1/S3/S5
// datapath on '1' bits and accumulates its terms. Option: SYND_CTRL_ZERO_FLAG_EN.
module synd_cal_ctrl_seq
    import synd_cal_ctrl_seq_pkg::*;
#(
    parameter int GF_LEN = 10,
    parameter int CW_LEN = 1023,
    parameter int CNT_W  = 10
) (
    input  logic                clk,
    input  logic                in_ctr_Srst_n,
    input  logic                in_start,
    input  logic                in_bit,
    input  logic                in_bit_valid,
    output logic                out_bit_ready,
    output logic                out_ctr_Srst,
    output logic                out_ctr_en,
    output logic                out_ctr_init,
    output logic [GF_LEN-1:0]   out_alpha,
    input  logic [GF_LEN-1:0]   in_synd1_TP,
    input  logic [GF_LEN-1:0]   in_synd3_TP,
    input  logic [GF_LEN-1:0]   in_synd5_TP,
    synd_cal_ctrl_seq_if.master synd_if,
    output logic                out_busy
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [CNT_W-1:0]  r_pos;
    logic [GF_LEN-1:0] r_alpha_pos;
    logic [GF_LEN-1:0] w_alpha_step;
    logic              r_pending;
    logic [GF_LEN-1:0] w_tp [3];
    logic              w_run;
    logic              w_init;
    logic              w_accept;
    logic              w_last;

    assign w_tp[0] = in_synd1_TP;
    assign w_tp[1] = in_synd3_TP;
    assign w_tp[2] = in_synd5_TP;

    assign w_run    = (r_state == ST_RUN);
    assign w_init   = (r_state == ST_INIT);
    assign w_accept = w_run & in_bit_valid;
    assign w_last   = w_accept & (r_pos == CNT_W'(CW_LEN - 1));

    gf10_alpha_step u_alpha_step (
        .i_a   (r_alpha_pos),
        .o_a_x (w_alpha_step)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_start)              w_state_next = ST_INIT;
            ST_INIT:                             w_state_next = ST_RUN;
            ST_RUN:   if (w_last)                w_state_next = ST_FLUSH;
            ST_FLUSH:                            w_state_next = ST_DONE;
            ST_DONE:  if (synd_if.in_synd_ready) w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    // The datapath term for a '1' bit lands one cycle after en, so pending marks the cycle to absorb it
    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_alpha_pos <= GF_LEN'(1);
            r_pending   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_accept & in_bit;
            if (w_init) begin
                r_pos       <= '0;
                r_alpha_pos <= GF_LEN'(1);
            end else if (w_accept) begin
                r_pos       <= r_pos + 1'b1;
                r_alpha_pos <= w_alpha_step;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_acc
            logic [GF_LEN-1:0] r_acc;
            always_ff @(posedge clk) begin
                if (!in_ctr_Srst_n || w_init) begin
                    r_acc <= '0;
                end else if (r_pending) begin
                    r_acc <= r_acc ^ w_tp[gi];
                end
            end
        end
    endgenerate

    assign out_ctr_Srst   = ~in_ctr_Srst_n;
    assign out_bit_ready  = w_run;
    assign out_ctr_en     = w_init | (w_accept & in_bit);
    assign out_ctr_init   = w_init;
    assign out_alpha      = w_run ? r_alpha_pos : '0;
    assign out_busy       = (r_state != ST_IDLE);

    assign synd_if.out_synd1      = g_acc[0].r_acc;
    assign synd_if.out_synd3      = g_acc[1].r_acc;
    assign synd_if.out_synd5      = g_acc[2].r_acc;
    assign synd_if.out_synd_valid = (r_state == ST_DONE);

`ifdef SYND_CTRL_ZERO_FLAG_EN
    assign synd_if.out_synd_zero = (r_state == ST_DONE) & ~|g_acc[0].r_acc
                                   & ~|g_acc[1].r_acc & ~|g_acc[2].r_acc;
`endif

endmodule

// File: tb/tb_synd_cal_ctrl_seq.sv
// Bench for synd_cal_ctrl_seq paired with a behavioural S1/S3/S5 datapath; scoreboard checks syndromes.
module tb_synd_cal_ctrl_seq;

    typedef struct packed {
        logic [9:0] s1;
        logic [9:0] s3;
        logic [9:0] s5;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_bit;
    logic       bit_valid;
    logic       bit_ready;
    logic       ctr_srst;
    logic       ctr_en;
    logic       ctr_init;
    logic       busy;
    logic [9:0] alpha;
    logic [9:0] tp1;
    logic [9:0] tp3;
    logic [9:0] tp5;

    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    exp_t exp_q[$];
    logic [1022:0] cw;

    always #5 clk = ~clk;

    synd_cal_ctrl_seq_if u_if ();

    synd_cal_ctrl_seq #(
        .GF_LEN (10),
        .CW_LEN (1023),
        .CNT_W  (10)
    ) u_dut (
        .clk           (clk),
        .in_ctr_Srst_n (rst_n),
        .in_start      (start),
        .in_bit        (in_bit),
        .in_bit_valid  (bit_valid),
        .out_bit_ready (bit_ready),
        .out_ctr_Srst  (ctr_srst),
        .out_ctr_en    (ctr_en),
        .out_ctr_init  (ctr_init),
        .out_alpha     (alpha),
        .in_synd1_TP   (tp1),
        .in_synd3_TP   (tp3),
        .in_synd5_TP   (tp5),
        .synd_if       (u_if),
        .out_busy      (busy)
    );

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] r = '0;
        logic [9:0] t = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) r = r ^ t;
            t = t[9] ? ({t[8:0], 1'b0} ^ 10'h009) : {t[8:0], 1'b0};
        end
        return r;
    endfunction

    // Behavioural syndrome datapath: terms registered one cycle after en
    always @(posedge clk) begin
        if (ctr_srst) begin
            tp1 <= '0; tp3 <= '0; tp5 <= '0;
        end else if (ctr_en) begin
            if (ctr_init) begin
                tp1 <= '0; tp3 <= '0; tp5 <= '0;
            end else begin
                tp1 <= alpha;
                tp3 <= gf_mul(alpha, gf_mul(alpha, alpha));
                tp5 <= gf_mul(gf_mul(alpha, gf_mul(alpha, alpha)), gf_mul(alpha, alpha));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_ready"}, bit_ready, 0);
        chk({tag, "_en"},    ctr_en, 0);
        chk({tag, "_init"},  ctr_init, 0);
        chk({tag, "_alpha"}, alpha, 0);
        chk({tag, "_srst"},  ctr_srst, 1);
        chk({tag, "_valid"}, u_if.out_synd_valid, 0);
        chk({tag, "_s1"},    u_if.out_synd1, 0);
        chk({tag, "_s3"},    u_if.out_synd3, 0);
        chk({tag, "_s5"},    u_if.out_synd5, 0);
`ifdef SYND_CTRL_ZERO_FLAG_EN
        chk({tag, "_zero"},  u_if.out_synd_zero, 0);
`endif
    endtask

    // Monitor: pops the scoreboard on each valid&ready handshake
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (u_if.out_synd_valid && u_if.in_synd_ready) begin
                chk("sb_nonempty", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("S1", u_if.out_synd1, e.s1);
                    chk("S3", u_if.out_synd3, e.s3);
                    chk("S5", u_if.out_synd5, e.s5);
`ifdef SYND_CTRL_ZERO_FLAG_EN
                    chk("zero_flag", u_if.out_synd_zero, (e.s1 == 0 && e.s3 == 0 && e.s5 == 0));
`endif
                end
                $display("txn %0d: S1=0x%03h S3=0x%03h S5=0x%03h", txn,
                         u_if.out_synd1, u_if.out_synd3, u_if.out_synd5);
                txn++;
            end
        end
    end

    task automatic pulse_start_and_init();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("init_en",    ctr_en, 1);
        chk("init_flag",  ctr_init, 1);
        chk("init_ready", bit_ready, 0);
    endtask

    task automatic feed_bits(input logic [1022:0] v, input int n, input bit gaps);
        logic [9:0] a_exp;
        for (int p = 0; p < n; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk); bit_valid = 1'b0; in_bit = 1'b1;
                end
            end
            @(negedge clk); bit_valid = 1'b1; in_bit = v[p]; #1;
            chk("bit_ready", bit_ready, 1);
            chk("en_on_bit", ctr_en, v[p]);
            if (p == 0 || p == 1 || p == 2 || p == 1022) begin
                case (p)
                    0:       a_exp = 10'h001;
                    1:       a_exp = 10'h002;
                    2:       a_exp = 10'h004;
                    default: a_exp = 10'h204;
                endcase
                chk("alpha_pos", alpha, a_exp);
            end
        end
    endtask

    task automatic run_frame(input logic [1022:0] v, input bit gaps, input int hold,
                             input logic [9:0] e1, input logic [9:0] e3, input logic [9:0] e5);
        exp_t e;
        e.s1 = e1; e.s3 = e3; e.s5 = e5;
        exp_q.push_back(e);
        pulse_start_and_init();
        feed_bits(v, 1023, gaps);
        @(negedge clk); bit_valid = 1'b0; in_bit = 1'b0; #1;
        chk("flush_valid", u_if.out_synd_valid, 0);
        chk("flush_ready", bit_ready, 0);
        chk("flush_busy",  busy, 1);
        @(negedge clk); #1;
        chk("done_valid", u_if.out_synd_valid, 1);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk); start = (c == hold / 2); #1;
            chk("hold_valid", u_if.out_synd_valid, 1);
            chk("hold_ready", bit_ready, 0);
            chk("hold_s1",    u_if.out_synd1, e1);
            chk("hold_s5",    u_if.out_synd5, e5);
        end
        @(negedge clk); start = 1'b0; u_if.in_synd_ready = 1'b1;
        @(negedge clk); u_if.in_synd_ready = 1'b0; #1;
        chk("idle_valid", u_if.out_synd_valid, 0);
        chk("idle_busy",  busy, 0);
        @(negedge clk); #1;
        chk("idle_stays", busy, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n = 1'b0; start = 1'b0; in_bit = 1'b0; bit_valid = 1'b0;
        u_if.in_synd_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("por");
        @(negedge clk); rst_n = 1'b1;

        cw = '0;                       run_frame(cw, 1'b0, 0,  10'h000, 10'h000, 10'h000);
        cw = '0; cw[1] = 1'b1;         run_frame(cw, 1'b0, 20, 10'h002, 10'h008, 10'h020);
        cw = '0; cw[2] = 1'b1;         run_frame(cw, 1'b0, 0,  10'h004, 10'h040, 10'h009);
        cw = '0; cw[1] = 1'b1; cw[2] = 1'b1;
        run_frame(cw, 1'b0, 0, 10'h006, 10'h048, 10'h029);
        run_frame(cw, 1'b1, 3, 10'h006, 10'h048, 10'h029);
        cw = '0; cw[0] = 1'b1; cw[1022] = 1'b1;
        run_frame(cw, 1'b0, 0, 10'h205, 10'h080, 10'h123);

        // Abort a frame at position 500; nothing may reach the scoreboard from it
        cw = '0; cw[1] = 1'b1; cw[7] = 1'b1;
        pulse_start_and_init();
        feed_bits(cw, 500, 1'b0);
        @(negedge clk); rst_n = 1'b0; bit_valid = 1'b0; in_bit = 1'b0;
        @(negedge clk); #1;
        check_reset("midrst");
        @(negedge clk); rst_n = 1'b1;
        cw = '0; cw[1] = 1'b1;         run_frame(cw, 1'b0, 0, 10'h002, 10'h008, 10'h020);

        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
